alu_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 32-bit ALU. It accepts operation requests (A, B, F) from two independent requesters over valid/ready handshakes and picks between them round-robin. It drives the combinational ALU from registered operands and captures Y/Zero/Overflow into a response register. It sits between the two ALU clients (e.g. the execute unit and the address unit) and the single ALU instance.

---
 rtl/alu_arbiter_if.sv | 28 ++
 rtl/alu_arbiter.sv | 66 ++++++
 tb/tb_alu_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: signal bundle between the two ALU clients, alu_arbiter and the shared ALU.
//   req0_* / req1_* : valid, ready, operands a/b and function f from each requester
//   alu_*           : registered operands/function to the ALU and its y/zero/ovf results
//   rsp*            : per-requester response pulse plus captured y/zero/ovf
interface alu_arbiter_if #(parameter int WIDTH = 32);
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]       req0_f, req1_f;
   logic [WIDTH-1:0] alu_a, alu_b, alu_y;
   logic [2:0]       alu_f;
   logic             alu_zero, alu_ovf;
   logic             rsp0_valid, rsp1_valid, rsp_zero, rsp_ovf;
   logic [WIDTH-1:0] rsp_y;
   modport master (
      output req0_valid, req0_a, req0_b, req0_f, req1_valid, req1_a, req1_b, req1_f,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y, rsp_zero, rsp_ovf
   );
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_f, req1_valid, req1_a, req1_b, req1_f,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y, rsp_zero, rsp_ovf,
      output alu_a, alu_b, alu_f,
      input  alu_y, alu_zero, alu_ovf
   );
   modport alu (
      input  alu_a, alu_b, alu_f,
      output alu_y, alu_zero, alu_ovf
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-port arbiter/sequencer for a shared combinational ALU.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus.slave  : req0/req1 valid-ready requests, registered ALU operands out,
//                ALU results in, one-cycle rsp0/rsp1 pulses with captured y/zero/ovf
module alu_arbiter #(
   parameter int   WIDTH     = 32,
   parameter logic PRIO_INIT = 1'b0
) (
   input logic        clk,
   input logic        rst_n,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t           state;
   logic             prio, owner, grant1, hs;
   logic [WIDTH-1:0] op_a, op_b;
   logic [2:0]       op_f;
   // req1 wins when it is alone or holds priority; otherwise any pending request is req0's
   assign grant1 = bus.req1_valid & (~bus.req0_valid | prio);
   assign hs = (state == IDLE) & (bus.req0_valid | bus.req1_valid);
   // gating with rst_n keeps ready low while reset is held even though state already reads IDLE
   assign bus.req0_ready = rst_n & hs & ~grant1;
   assign bus.req1_ready = rst_n & hs & grant1;
   assign op_a = grant1 ? bus.req1_a : bus.req0_a;
   assign op_b = grant1 ? bus.req1_b : bus.req0_b;
   assign op_f = grant1 ? bus.req1_f : bus.req0_f;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         prio           <= PRIO_INIT;
         owner          <= 1'b0;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.alu_f      <= '0;
         bus.rsp_y      <= '0;
         bus.rsp_zero   <= 1'b0;
         bus.rsp_ovf    <= 1'b0;
         bus.rsp0_valid <= 1'b0;
         bus.rsp1_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (hs) begin
               bus.alu_a <= op_a;
               bus.alu_b <= op_b;
               bus.alu_f <= op_f;
               owner     <= grant1;
               prio      <= ~grant1;
               state     <= EXEC;
            end
            EXEC: begin
               bus.rsp_y      <= bus.alu_y;
               bus.rsp_zero   <= bus.alu_zero;
               bus.rsp_ovf    <= bus.alu_ovf;
               bus.rsp0_valid <= ~owner;
               bus.rsp1_valid <= owner;
               state          <= RESP;
            end
            default: begin
               bus.rsp0_valid <= 1'b0;
               bus.rsp1_valid <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;
   logic clk, rst_n;
   int   n_checks = 0, n_fail = 0, cyc = 0;
   typedef struct {logic p; logic [31:0] y; logic z; logic o;} exp_t;
   exp_t sb[$];
   exp_t m_e;
   alu_arbiter_if #(.WIDTH(32)) bus();
   alu_arbiter #(.WIDTH(32), .PRIO_INIT(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
      logic [31:0] bb, s, y;
      logic v;
      bb = f[2] ? ~b : b;
      s  = a + bb + {31'b0, f[2]};
      y  = f[1:0] == 2'b00 ? (a & bb) : f[1:0] == 2'b01 ? (a | bb) : f[1:0] == 2'b10 ? s : {31'b0, s[31]};
      v  = (f[1:0] == 2'b10) & (a[31] == bb[31]) & (s[31] != a[31]);
      return {y, y == 32'd0, v};
   endfunction
   assign {bus.alu_y, bus.alu_zero, bus.alu_ovf} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_f);
   always @(negedge clk) begin
      if (bus.rsp0_valid || bus.rsp1_valid) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: got rsp0=%b rsp1=%b y=%h, want no response", bus.rsp0_valid, bus.rsp1_valid, bus.rsp_y);
         end else begin
            m_e = sb.pop_front();
            if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_y, bus.rsp_zero, bus.rsp_ovf} !== {m_e.p, ~m_e.p, m_e.y, m_e.z, m_e.o}) begin
               n_fail++;
               $display("FAIL rsp_data: got rsp1=%b rsp0=%b y=%h z=%b o=%b, want rsp1=%b rsp0=%b y=%h z=%b o=%b",
                        bus.rsp1_valid, bus.rsp0_valid, bus.rsp_y, bus.rsp_zero, bus.rsp_ovf, m_e.p, ~m_e.p, m_e.y, m_e.z, m_e.o);
            end
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end
   task automatic drive(input logic p, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
      if (p) begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_f = f;
      end else begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_f = f;
      end
   endtask
   task automatic do_op(input logic p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        input logic [31:0] y, input logic z, input logic o, output int waited);
      sb.push_back('{p: p, y: y, z: z, o: o});
      drive(p, 1'b1, a, b, f);
      waited = -1;
      for (int t = 0; t < 20; t++) begin
         if (t > 0) @(negedge clk); else #1;
         if (p ? bus.req1_ready : bus.req0_ready) begin
            waited = t;
            break;
         end
      end
      n_checks++;
      if (waited < 0) begin
         n_fail++;
         $display("FAIL ready_timeout: got no req%0d_ready in 20 cycles, want ready", p);
         drive(p, 1'b0, a, b, f);
         void'(sb.pop_back());
         return;
      end
      n_checks++;
      if ((p ? bus.req0_ready : bus.req1_ready) !== 1'b0) begin
         n_fail++;
         $display("FAIL other_ready: got 1, want 0 while req%0d granted", p);
      end
      @(posedge clk);
      #1 drive(p, 1'b0, a, b, f);
      @(negedge clk);
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'b0) begin
         n_fail++;
         $display("FAIL exec_cycle: got rdy0/rdy1/rsp0/rsp1=%b, want 0000",
                  {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid});
      end
      @(negedge clk);
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp1_valid, bus.rsp0_valid} !== {2'b00, p, ~p}) begin
         n_fail++;
         $display("FAIL resp_cycle: got rdy0/rdy1/rsp1/rsp0=%b, want %b",
                  {bus.req0_ready, bus.req1_ready, bus.rsp1_valid, bus.rsp0_valid}, {2'b00, p, ~p});
      end
      @(negedge clk);
      n_checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL pulse_width: got rsp0/rsp1=%b, want 00", {bus.rsp0_valid, bus.rsp1_valid});
      end
   endtask
   task automatic check_reset_outputs(input string name);
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.alu_a, bus.alu_b, bus.alu_f,
           bus.rsp_y, bus.rsp_zero, bus.rsp_ovf} !== '0) begin
         n_fail++;
         $display("FAIL %s: got rdy=%b%b rsp=%b%b alu_a=%h alu_b=%h alu_f=%b y=%h z=%b o=%b, want all 0", name,
                  bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.alu_a, bus.alu_b, bus.alu_f,
                  bus.rsp_y, bus.rsp_zero, bus.rsp_ovf);
      end
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_idle");
      drive(1'b0, 1'b1, 32'd9, 32'd9, 3'b010);
      drive(1'b1, 1'b1, 32'd9, 32'd9, 3'b010);
      @(negedge clk);
      check_reset_outputs("reset_valid_held");
      drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("after_release");
   endtask
   task automatic test_sum;
      int w;
      do_op(1'b0, 32'd5, 32'd3, 3'b010, 32'd8, 1'b0, 1'b0, w);
      n_checks++;
      if (w !== 0) begin
         n_fail++;
         $display("FAIL ready_same_cycle: got wait=%0d, want 0", w);
      end
   endtask
   task automatic test_sub_slt;
      int w;
      do_op(1'b1, 32'd3, 32'd5, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0, w);
      do_op(1'b1, 32'd3, 32'd5, 3'b111, 32'd1, 1'b0, 1'b0, w);
      do_op(1'b1, 32'd5, 32'd5, 3'b110, 32'd0, 1'b1, 1'b0, w);
   endtask
   task automatic test_overflow;
      int w;
      do_op(1'b0, 32'h7FFF_FFFF, 32'd1, 3'b010, 32'h8000_0000, 1'b0, 1'b1, w);
      do_op(1'b0, 32'h8000_0000, 32'd1, 3'b110, 32'h7FFF_FFFF, 1'b0, 1'b1, w);
   endtask
   task automatic test_random;
      int w;
      logic [31:0] a, b;
      logic [2:0] f;
      logic p;
      for (int i = 0; i < 8; i++) begin
         a = $urandom; b = $urandom; f = 3'($urandom_range(0, 7)); p = 1'($urandom_range(0, 1));
         do_op(p, a, b, f, alu_ref(a, b, f)[33:2], alu_ref(a, b, f)[1], alu_ref(a, b, f)[0], w);
      end
   endtask
   task automatic test_contention;
      logic [31:0] a0 [2] = '{32'd10, 32'd12};
      logic [31:0] b0 [2] = '{32'd20, 32'd10};
      logic [2:0]  f0 [2] = '{3'b010, 3'b110};
      logic [31:0] a1 [2] = '{32'hF0, 32'hF0};
      logic [31:0] b1 [2] = '{32'h0F, 32'h3C};
      logic [2:0]  f1 [2] = '{3'b001, 3'b000};
      int last, got;
      rst_n = 1'b0;
      drive(1'b0, 1'b1, a0[0], b0[0], f0[0]);
      drive(1'b1, 1'b1, a1[0], b1[0], f1[0]);
      sb.push_back('{p: 1'b0, y: 32'd30,  z: 1'b0, o: 1'b0});
      sb.push_back('{p: 1'b1, y: 32'hFF,  z: 1'b0, o: 1'b0});
      sb.push_back('{p: 1'b0, y: 32'd2,   z: 1'b0, o: 1'b0});
      sb.push_back('{p: 1'b1, y: 32'h30,  z: 1'b0, o: 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
      last = 0;
      for (int k = 0; k < 4; k++) begin
         got = 0;
         for (int t = 0; t < 10; t++) begin
            if (t > 0) @(negedge clk); else #1;
            if (bus.req0_ready || bus.req1_ready) begin
               got = 1;
               break;
            end
         end
         n_checks++;
         if (got == 0) begin
            n_fail++;
            $display("FAIL contention_timeout: got no ready for grant %0d, want ready", k);
            break;
         end
         if ({bus.req1_ready, bus.req0_ready} !== {1'(k % 2), ~1'(k % 2)}) begin
            n_fail++;
            $display("FAIL grant_order: got rdy1/rdy0=%b%b at grant %0d, want %b%b", bus.req1_ready, bus.req0_ready, k, 1'(k % 2), ~1'(k % 2));
         end
         if (k > 0) begin
            n_checks++;
            if (cyc - last !== 3) begin
               n_fail++;
               $display("FAIL grant_spacing: got %0d cycles, want 3", cyc - last);
            end
         end
         last = cyc;
         @(posedge clk);
         #1;
         if (k == 0) drive(1'b0, 1'b1, a0[1], b0[1], f0[1]);
         else if (k == 1) drive(1'b1, 1'b1, a1[1], b1[1], f1[1]);
         else drive(1'(k % 2), 1'b0, 32'd0, 32'd0, 3'd0);
      end
      repeat (3) @(negedge clk);
   endtask
   task automatic test_reset_mid_op;
      int w;
      drive(1'b0, 1'b1, 32'd1, 32'd1, 3'b010);
      w = -1;
      for (int t = 0; t < 20; t++) begin
         if (t > 0) @(negedge clk); else #1;
         if (bus.req0_ready) begin
            w = t;
            break;
         end
      end
      n_checks++;
      if (w < 0) begin
         n_fail++;
         $display("FAIL midreset_ready: got no ready, want ready");
      end
      @(posedge clk);
      #1 drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      #1 rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_reset_outputs("reset_in_exec");
      end
      rst_n = 1'b1;
      do_op(1'b0, 32'd21, 32'd21, 3'b010, 32'd42, 1'b0, 1'b0, w);
   endtask
   task automatic test_withdraw_hold;
      for (int hold = 0; hold < 2; hold++) begin
         sb.push_back('{p: 1'b0, y: 32'h0F, z: 1'b0, o: 1'b0});
         drive(1'b0, 1'b1, 32'hFF, 32'h0F, 3'b000);
         #1;
         n_checks++;
         if (bus.req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL withdraw_req0_ready: got %b, want 1", bus.req0_ready);
         end
         @(posedge clk);
         #1 drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
         if (hold == 1) sb.push_back('{p: 1'b1, y: 32'd7, z: 1'b0, o: 1'b0});
         drive(1'b1, 1'b1, 32'd4, 32'd3, 3'b001);
         @(posedge clk);
         #1;
         if (hold == 0) drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
         @(negedge clk);
         @(negedge clk);
         n_checks++;
         if (bus.req1_ready !== 1'(hold)) begin
            n_fail++;
            $display("FAIL first_idle_req1_ready: got %b, want %b (hold=%0d)", bus.req1_ready, 1'(hold), hold);
         end
         @(posedge clk);
         #1 drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
         repeat (3) @(negedge clk);
      end
   endtask
   initial begin
      test_reset;
      test_sum;
      test_sub_slt;
      test_overflow;
      test_random;
      test_contention;
      test_reset_mid_op;
      test_withdraw_hold;
      repeat (2) @(negedge clk);
      n_checks++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
